pc_redirect_ctrl: RTL
=====================

Name: pc_redirect_ctrl

Overview:
- Sequences the core's program counter. Arbitrates between sequential fetch, taken branch/jump, mret return and interrupt entry.
- Consumes the branch-resolve decision produced in decode and owns the PC register.
- Generates the one-cycle flush that kills the wrong-path instruction in fetch.
- Sits between the branch logic and instruction memory in the two-stage pipeline.

Parameters:
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset
PC_STEP, 4, sequential PC increment in bytes

Ports:
clk  input  1  core clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
stall  input  1  memory/pipeline stall; freezes PC and state
branch_taken  input  1  decode resolved a taken branch or jump (branch mux select = branch)
branch_target  input  32  target address for branch_taken
mret  input  1  decode holds an mret instruction
mepc  input  32  return address for mret
irq_req  input  1  level interrupt request from interrupt controller
irq_vector  input  32  handler address, sampled in VEC_WAIT
pc  output  32  current fetch address (registered)
flush  output  1  kill instruction currently in fetch
irq_ack  output  1  one-cycle pulse: interrupt entry committed
save_pc_en  output  1  one-cycle pulse: write save_pc to mepc
save_pc  output  32  address to resume at after handler

Behaviour:
- Reset: pc=RESET_VECTOR, state=RUN, irq_pending=0. flush, irq_ack and save_pc_en are 0; save_pc=0. Reset mid-operation (any state) aborts the operation immediately, with no ack and no save.
- irq_pending: set when irq_req=1; cleared only by the irq_ack pulse or reset. Sets even while stalled.
- stall=1 in any state: pc and state hold, and all pulse outputs are 0.
  - branch_taken and mret are ignored during stall; decode re-presents them.
- States: RUN, FLUSH, VEC_WAIT, IRQ_ENTRY.
- RUN (stall=0). Priority is mret > branch_taken > irq_pending > sequential.
  - mret: pc<=mepc; go to FLUSH.
  - branch_taken: pc<=branch_target; go to FLUSH.
  - irq_pending with no redirect this cycle:
    - save_pc<=pc, save_pc_en pulses next cycle.
    - pc holds; go to VEC_WAIT.
  - Otherwise pc<=pc+PC_STEP (32-bit wrap, 32'hFFFF_FFFC+4=0).
- FLUSH:
  - flush=1 for exactly this cycle.
  - branch_taken and mret are ignored, because their instruction is the one being killed.
  - pc<=pc+PC_STEP; go to RUN.
  - A pending interrupt waits until RUN, so back-to-back redirects and interrupts never overlap.
- VEC_WAIT:
  - flush=1; irq_vector is sampled at the end of this cycle.
  - pc<=irq_vector; go to IRQ_ENTRY.
- IRQ_ENTRY:
  - irq_ack=1 and flush=1 for this cycle; irq_pending clears.
  - pc<=pc+PC_STEP; go to RUN.
- Latencies:
  - Redirect: target appears on pc 1 cycle after branch_taken or mret.
  - Interrupt: handler address appears on pc 2 cycles after RUN accepts the pending interrupt; irq_ack pulses in that same cycle.
- Simultaneous branch_taken and irq in RUN: the branch wins and the interrupt is taken in the first RUN cycle after FLUSH. save_pc then equals branch_target+PC_STEP, the first non-killed instruction.
- Alignment: targets are used as given; misalignment checking is done elsewhere.

Optional Feature:
- Macro: PC_REDIRECT_STATS_EN.
- With the macro defined:
  - Adds outputs stat_redirects[31:0] and stat_irqs[31:0].
  - stat_redirects increments on each accepted branch or mret; stat_irqs increments on each irq_ack.
  - Both counters saturate at 32'hFFFF_FFFF and reset to 0.
- Without the macro: the outputs and counters are absent and all other behaviour is identical.

Test Plan:
- Reset, then 3 unstalled cycles -> pc=0x0, 0x4, 0x8, 0xC; flush=0 throughout.
- pc=0x10 with branch_taken=1, target=0x100 -> next cycle pc=0x100 and flush=1; following cycle pc=0x104 and flush=0.
- Branch into FLUSH: branch_taken=1 presented during the FLUSH cycle -> ignored; pc=0x104, then 0x108.
- irq_req pulse at pc=0x20, vector=0x800 -> save_pc_en pulses with save_pc=0x20; pc holds 0x20 in VEC_WAIT, then pc=0x800 with irq_ack=1, then pc=0x804.
- Branch to 0x200 and irq in the same cycle -> branch first (pc=0x200, then 0x204); interrupt taken next with save_pc=0x204; pc=vector 2 cycles later.
- stall=1 for 3 cycles in VEC_WAIT, and separately reset asserted in IRQ_ENTRY:
  - Stall -> pc and state hold, no pulses, sequence resumes unchanged.
  - Reset -> pc=RESET_VECTOR, irq_ack never seen, irq_pending=0.

Source files
------------

// File: rtl/pc_redirect_ctrl.sv
// Program-counter sequencer: sequential fetch, branch/mret redirect, interrupt entry and wrong-path flush.
// Optional event counters are compiled in with `define PC_REDIRECT_STATS_EN.
module pc_redirect_ctrl #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter int unsigned PC_STEP      = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic        mret,
   input  logic [31:0] mepc,
   input  logic        irq_req,
   input  logic [31:0] irq_vector,
   output logic [31:0] pc,
   output logic        flush,
   output logic        irq_ack,
   output logic        save_pc_en,
   output logic [31:0] save_pc
`ifdef PC_REDIRECT_STATS_EN
   ,
   output logic [31:0] stat_redirects,
   output logic [31:0] stat_irqs
`endif
);

   typedef enum logic [1:0] {
      RUN,
      FLUSH,
      VEC_WAIT,
      IRQ_ENTRY
   } state_t;

   localparam logic [31:0] STEP = 32'(PC_STEP);

   state_t      state;
   state_t      state_nxt;
   logic [31:0] pc_nxt;
   logic [31:0] save_pc_nxt;
   logic        irq_pending;
   logic        irq_seen;

   // A request arriving this cycle is visible immediately, so the interrupted pc is the current one.
   assign irq_seen = irq_pending | irq_req;

   always_comb begin
      state_nxt   = state;
      pc_nxt      = pc;
      save_pc_nxt = save_pc;
      flush       = 1'b0;
      irq_ack     = 1'b0;
      save_pc_en  = 1'b0;
      if (!stall) begin
         case (state)
            RUN: begin
               if (mret) begin
                  pc_nxt    = mepc;
                  state_nxt = FLUSH;
               end else if (branch_taken) begin
                  pc_nxt    = branch_target;
                  state_nxt = FLUSH;
               end else if (irq_seen) begin
                  save_pc_nxt = pc;
                  state_nxt   = VEC_WAIT;
               end else begin
                  pc_nxt = pc + STEP;
               end
            end
            FLUSH: begin
               // The redirect request in decode belongs to the killed instruction.
               flush     = 1'b1;
               pc_nxt    = pc + STEP;
               state_nxt = RUN;
            end
            VEC_WAIT: begin
               flush      = 1'b1;
               save_pc_en = 1'b1;
               pc_nxt     = irq_vector;
               state_nxt  = IRQ_ENTRY;
            end
            IRQ_ENTRY: begin
               flush     = 1'b1;
               irq_ack   = 1'b1;
               pc_nxt    = pc + STEP;
               state_nxt = RUN;
            end
            default: state_nxt = RUN;
         endcase
      end
      // Reset aborts whatever is in flight without acknowledging or saving.
      if (reset) begin
         flush      = 1'b0;
         irq_ack    = 1'b0;
         save_pc_en = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= RUN;
         pc          <= RESET_VECTOR;
         save_pc     <= 32'h0;
         irq_pending <= 1'b0;
      end else begin
         state       <= state_nxt;
         pc          <= pc_nxt;
         save_pc     <= save_pc_nxt;
         irq_pending <= irq_ack ? 1'b0 : irq_seen;
      end
   end

`ifdef PC_REDIRECT_STATS_EN
   logic redirect_acc;

   assign redirect_acc = (state == RUN) && !stall && (mret || branch_taken);

   // Saturating counters: they stop at all-ones rather than wrapping.
   always_ff @(posedge clk) begin
      if (reset) begin
         stat_redirects <= 32'h0;
         stat_irqs      <= 32'h0;
      end else begin
         if (redirect_acc && (stat_redirects != 32'hFFFF_FFFF))
            stat_redirects <= stat_redirects + 32'h1;
         if (irq_ack && (stat_irqs != 32'hFFFF_FFFF))
            stat_irqs <= stat_irqs + 32'h1;
      end
   end
`endif

endmodule
